// File: rtl/calc_op_scheduler.sv
`default_nettype none
// ============================================================================
// calc_op_scheduler : arbitrates calculator op requests, sequences add/sub/mul/div
// Revision 1.0
// ============================================================================
module calc_op_scheduler #(
   parameter int W  = 7,
   parameter int RW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic          add_req,
   input  logic          sub_req,
   input  logic          mul_req,
   input  logic          div_req,
   output logic [RW-1:0] result,
   output logic          neg,
   output logic          error,
   output logic          busy,
   output logic          done,
   output logic          overrun
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;

   localparam logic [2:0] LAST_ITER = 3'd6;

   state_t        state;
   op_t           cur_op, pend_op, req_op, launch_op;
   logic          any_req, pend_valid, launch_go;
   logic [W-1:0]  op_a, op_b, pend_a, pend_b, launch_a, launch_b;
   logic [2:0]    cnt;
   logic [RW-1:0] acc, mcand, mul_acc_nxt, quo_rnd;
   logic [W-1:0]  mplier, dvd, rem, div_rem_nxt, div_sub, abs_diff, quo_nxt;
   logic [W-2:0]  quo;
   logic [W:0]    div_shift, sum;
   logic          div_ge, round_up, a_ge_b;

   always_comb begin
      any_req = add_req | sub_req | mul_req | div_req;
      if (add_req)      req_op = OP_ADD;
      else if (sub_req) req_op = OP_SUB;
      else if (div_req) req_op = OP_DIV;
      else              req_op = OP_MUL;
      launch_go = (state == S_IDLE) && (pend_valid || any_req);
      launch_op = pend_valid ? pend_op : req_op;
      launch_a  = pend_valid ? pend_a  : a;
      launch_b  = pend_valid ? pend_b  : b;
   end

   always_comb begin
      sum         = {1'b0, op_a} + {1'b0, op_b};
      a_ge_b      = (op_a >= op_b);
      abs_diff    = a_ge_b ? (op_a - op_b) : (op_b - op_a);
      mul_acc_nxt = mplier[0] ? (acc + mcand) : acc;
      // remainder always stays below the divisor, so the low W bits of the subtraction are exact
      div_shift   = {rem, dvd[W-1]};
      div_ge      = (div_shift >= {1'b0, op_b});
      div_sub     = div_shift[W-1:0] - op_b;
      div_rem_nxt = div_ge ? div_sub : div_shift[W-1:0];
      quo_nxt     = {quo, div_ge};
      round_up    = ({div_rem_nxt, 1'b0} >= {1'b0, op_b});
      quo_rnd     = {{(RW-W){1'b0}}, quo_nxt} + {{(RW-1){1'b0}}, round_up};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         result     <= '0;
         neg        <= 1'b0;
         error      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         pend_valid <= 1'b0;
         pend_op    <= OP_ADD;
         pend_a     <= '0;
         pend_b     <= '0;
         cur_op     <= OP_ADD;
         op_a       <= '0;
         op_b       <= '0;
         cnt        <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         dvd        <= '0;
         rem        <= '0;
         quo        <= '0;
      end else begin
         done <= 1'b0;

         // Slot handling: a freed slot in IDLE is refilled by a same-cycle request
         if (state == S_IDLE) begin
            if (pend_valid) begin
               pend_valid <= any_req;
               pend_op    <= req_op;
               pend_a     <= a;
               pend_b     <= b;
            end
         end else if (any_req) begin
            if (pend_valid) begin
               overrun <= 1'b1;
            end else begin
               pend_valid <= 1'b1;
               pend_op    <= req_op;
               pend_a     <= a;
               pend_b     <= b;
            end
         end

         case (state)
            S_IDLE: begin
               if (launch_go) begin
                  state  <= S_RUN;
                  busy   <= 1'b1;
                  cur_op <= launch_op;
                  op_a   <= launch_a;
                  op_b   <= launch_b;
                  cnt    <= '0;
                  acc    <= '0;
                  mcand  <= {{(RW-W){1'b0}}, launch_a};
                  mplier <= launch_b;
                  dvd    <= launch_a;
                  rem    <= '0;
                  quo    <= '0;
               end
            end
            S_RUN: begin
               cnt <= cnt + 3'd1;
               case (cur_op)
                  OP_ADD: begin
                     result <= {{(RW-W-1){1'b0}}, sum};
                     neg    <= 1'b0;
                     error  <= 1'b0;
                     state  <= S_DONE;
                     done   <= 1'b1;
                  end
                  OP_SUB: begin
                     result <= {{(RW-W){1'b0}}, abs_diff};
                     neg    <= ~a_ge_b;
                     error  <= 1'b0;
                     state  <= S_DONE;
                     done   <= 1'b1;
                  end
                  OP_MUL: begin
                     acc    <= mul_acc_nxt;
                     mcand  <= {mcand[RW-2:0], 1'b0};
                     mplier <= {1'b0, mplier[W-1:1]};
                     if (cnt == LAST_ITER) begin
                        result <= mul_acc_nxt;
                        neg    <= 1'b0;
                        error  <= 1'b0;
                        state  <= S_DONE;
                        done   <= 1'b1;
                     end
                  end
                  OP_DIV: begin
                     if (op_b == '0) begin
                        error <= 1'b1;
                        neg   <= 1'b0;
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        rem <= div_rem_nxt;
                        quo <= quo_nxt[W-2:0];
                        dvd <= {dvd[W-2:0], 1'b0};
                        if (cnt == LAST_ITER) begin
                           result <= quo_rnd;
                           neg    <= 1'b0;
                           error  <= 1'b0;
                           state  <= S_DONE;
                           done   <= 1'b1;
                        end
                     end
                  end
                  default: state <= S_DONE;
               endcase
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_op_scheduler.sv
`default_nettype none
// tb_calc_op_scheduler : directed and random requests checked against a behavioural calculator model
module tb_calc_op_scheduler;
   localparam int W  = 7;
   localparam int RW = 14;
   localparam logic [3:0] R_NONE = 4'b0000;
   localparam logic [3:0] R_ADD  = 4'b1000;
   localparam logic [3:0] R_SUB  = 4'b0100;
   localparam logic [3:0] R_MUL  = 4'b0010;
   localparam logic [3:0] R_DIV  = 4'b0001;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic          add_req = 1'b0, sub_req = 1'b0, mul_req = 1'b0, div_req = 1'b0;
   logic [RW-1:0] result;
   logic          neg, error, busy, done, overrun;

   always #5 clk = ~clk;

   calc_op_scheduler #(.W(W), .RW(RW)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .add_req(add_req), .sub_req(sub_req), .mul_req(mul_req), .div_req(div_req),
      .result(result), .neg(neg), .error(error), .busy(busy), .done(done), .overrun(overrun)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Behavioural model: ops 0=add 1=sub 2=mul 3=div; m_left = busy cycles remaining
   int m_left = 0;
   int m_res = 0;
   int m_neg = 0, m_err = 0, m_ovr = 0;
   int p_valid = 0, p_op = 0, p_a = 0, p_b = 0;
   int c_op = 0, c_a = 0, c_b = 0;

   function automatic int pick(input logic [3:0] r);
      if (r[3]) return 0;
      if (r[2]) return 1;
      if (r[0]) return 3;
      if (r[1]) return 2;
      return -1;
   endfunction

   task automatic launch(input int op, input int xa, input int xb);
      c_op = op; c_a = xa; c_b = xb;
      m_left = (op == 2 || (op == 3 && xb != 0)) ? 8 : 2;
   endtask

   task automatic publish();
      int q, r;
      case (c_op)
         0: begin m_res = c_a + c_b; m_neg = 0; m_err = 0; end
         1: begin
            if (c_a >= c_b) begin m_res = c_a - c_b; m_neg = 0; end
            else            begin m_res = c_b - c_a; m_neg = 1; end
            m_err = 0;
         end
         2: begin m_res = c_a * c_b; m_neg = 0; m_err = 0; end
         default: begin
            if (c_b == 0) begin m_err = 1; m_neg = 0; end
            else begin
               q = c_a / c_b; r = c_a % c_b;
               if (2 * r >= c_b) q = q + 1;
               m_res = q; m_neg = 0; m_err = 0;
            end
         end
      endcase
   endtask

   task automatic model_edge(input logic rn, input logic [3:0] r, input int xa, input int xb);
      int op;
      op = pick(r);
      if (!rn) begin
         m_left = 0; m_res = 0; m_neg = 0; m_err = 0; m_ovr = 0; p_valid = 0;
      end else if (m_left == 0) begin
         if (p_valid != 0) begin
            launch(p_op, p_a, p_b);
            p_valid = (op >= 0) ? 1 : 0;
            p_op = op; p_a = xa; p_b = xb;
         end else if (op >= 0) begin
            launch(op, xa, xb);
         end
      end else begin
         if (op >= 0) begin
            if (p_valid != 0) m_ovr = 1;
            else begin p_valid = 1; p_op = op; p_a = xa; p_b = xb; end
         end
         m_left--;
         if (m_left == 1) publish();
      end
   endtask

   task automatic step(input logic rn, input logic [3:0] r, input int xa, input int xb);
      rst = rn;
      {add_req, sub_req, mul_req, div_req} = r;
      a = W'(xa); b = W'(xb);
      @(posedge clk);
      model_edge(rn, r, xa, xb);
      @(negedge clk);
      chk("busy",    int'(busy),    (m_left > 0) ? 1 : 0);
      chk("done",    int'(done),    (m_left == 1) ? 1 : 0);
      chk("result",  int'(result),  m_res);
      chk("neg",     int'(neg),     m_neg);
      chk("error",   int'(error),   m_err);
      chk("overrun", int'(overrun), m_ovr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, R_NONE, int'(a), int'(b));
   endtask

   initial begin
      logic [3:0] rq;
      int ra, rb;
      logic rn;

      step(1'b0, R_NONE, 0, 0);
      step(1'b0, R_NONE, 0, 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_result", int'(result), 0);

      step(1'b1, R_ADD, 45, 67); idle(1);
      chk("add_45_67", int'(result), 112);
      chk("add_done", int'(done), 1);
      idle(1);

      step(1'b1, R_SUB, 12, 30); idle(1);
      chk("sub_12_30", int'(result), 18);
      chk("sub_12_30_neg", int'(neg), 1);
      idle(1);
      step(1'b1, R_SUB, 30, 12); idle(1);
      chk("sub_30_12_neg", int'(neg), 0);
      idle(1);

      step(1'b1, R_MUL, 99, 99); idle(2);
      step(1'b1, R_NONE, 0, 99); idle(4);
      chk("mul_99_99", int'(result), 9801);
      chk("mul_done", int'(done), 1);
      idle(1);

      step(1'b1, R_DIV, 7, 2); idle(7);
      chk("div_7_2", int'(result), 4);
      idle(1);
      step(1'b1, R_DIV, 99, 2); idle(7);
      chk("div_99_2", int'(result), 50);
      idle(1);
      step(1'b1, R_DIV, 10, 3); idle(7);
      chk("div_10_3", int'(result), 3);
      idle(1);
      step(1'b1, R_DIV, 5, 0); idle(1);
      chk("div0_err", int'(error), 1);
      chk("div0_hold", int'(result), 3);
      chk("div0_done", int'(done), 1);
      idle(1);

      step(1'b1, R_ADD | R_MUL, 3, 4); idle(1);
      chk("prio_add", int'(result), 7);
      idle(10);
      chk("prio_ovr", int'(overrun), 0);

      step(1'b1, R_MUL, 5, 6); idle(1);
      step(1'b1, R_DIV, 100, 7);
      step(1'b1, R_ADD, 1, 1); idle(4);
      chk("pend_mul", int'(result), 30);
      idle(9);
      chk("pend_div", int'(result), 14);
      chk("pend_ovr", int'(overrun), 1);
      idle(1);

      step(1'b1, R_MUL, 99, 99); idle(3);
      step(1'b0, R_NONE, 99, 99);
      chk("abort_result", int'(result), 0);
      chk("abort_ovr", int'(overrun), 0);
      step(1'b1, R_NONE, 0, 0);
      step(1'b1, R_ADD, 2, 3); idle(1);
      chk("abort_add", int'(result), 5);
      idle(1);

      for (int i = 0; i < 1500; i++) begin
         rq = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
         ra = int'($urandom_range(0, 127));
         rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
         rn = ($urandom_range(0, 249) != 0);
         step(rn, rq, ra, rb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/calc_op_scheduler.md
Name: calc_op_scheduler

Overview:
- Sequences a shared iterative arithmetic unit for the two-operand BCD-entry calculator.
- Accepts one-cycle operation request pulses (add, subtract, multiply, divide) from the edge detectors and arbitrates simultaneous requests by fixed priority.
- Runs add/subtract in one cycle and multiply/divide as 7-iteration shift-add / restoring loops, with a one-deep pending slot for requests arriving while busy.
- Delivers a 14-bit result with negative and error flags to the display encoder.

Parameters:
- W, 7, operand width in bits; operands range 0..2^W-1.
- RW, 14, result width in bits (2*W).

Ports:
- clk  input  1  system clock (divided clock domain); all logic on posedge.
- rst  input  1  synchronous active-low reset.
- a  input  W  operand A (minuend / dividend / addend), sampled at accept.
- b  input  W  operand B (subtrahend / divisor), sampled at accept.
- add_req  input  1  one-cycle add request.
- sub_req  input  1  one-cycle subtract request.
- mul_req  input  1  one-cycle multiply request.
- div_req  input  1  one-cycle divide request.
- result  output  RW  last completed result magnitude.
- neg  output  1  result is negative (subtract only).
- error  output  1  last operation was divide-by-zero.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse when result, neg and error update.
- overrun  output  1  sticky: a request was dropped because the pending slot was full.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, result=0, neg=0, error=0, busy=0, done=0, overrun=0, pending empty, iteration counter=0.
- Priority for requests in the same cycle: add > sub > div > mul. Lower-priority requests in that cycle are discarded; they are not pended and do not set overrun.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if pending is valid, launch the pending op with its stored operands. Otherwise, if any request is high, launch the highest-priority one with a/b sampled at that edge. The next state is RUN.
  - RUN: executes for L cycles, then moves to DONE.
    - L=1 for add, sub and divide-by-zero.
    - L=7 for mul and div (counter 0..6; exits when counter=6).
  - DONE: done=1 for exactly this cycle; result/neg/error are already updated at its entry edge. The next state is always IDLE.
- Latency: a request in cycle 0 gives RUN in cycles 1..L, done in cycle L+1, and the next launch no earlier than cycle L+2. busy=1 in cycles 1..L+1.
- Pending slot: any request seen while busy=1 is stored with a, b and op (priority applied among simultaneous ones).
  - If the slot is already full, the request is dropped and overrun is set to 1. overrun stays 1 until reset.
  - When IDLE consumes the pending slot, a new request in that same cycle fills the freed slot.
- Add: result = a+b, neg=0, error=0.
- Sub: if a>=b then result=a-b, neg=0; else result=b-a, neg=1. error=0.
- Mul: unsigned shift-add, one multiplier bit per RUN cycle, LSB first. result = a*b, zero-extended to RW. neg=0, error=0.
- Div, b=0: error=1, neg=0, result holds its previous value, L=1.
- Div, b!=0: restoring division, one quotient bit per RUN cycle, MSB first.
  - After the last iteration, if 2*remainder >= b then q = q+1 (round half up).
  - result = q, zero-extended. neg=0, error=0.
- result, neg and error change only at the edge entering DONE, and hold between operations.
- Reset asserted mid-RUN aborts the operation: no done pulse, all outputs return to reset values, pending is cleared.
- Operands are held internally once launched; changes on a/b during RUN have no effect.

Test Plan:
- Reset, then add_req with a=45, b=67 in cycle 0 -> busy in cycles 1-2; done in cycle 2 with result=112, neg=0, error=0.
- sub_req with a=12, b=30 -> result=18, neg=1. Then sub_req with a=30, b=12 -> result=18, neg=0.
- mul_req with a=99, b=99 in cycle 0 -> done in cycle 8 with result=9801. Change a to 0 in cycle 3 -> result still 9801.
- div: a=7, b=2 -> result=4. a=99, b=2 -> result=50. a=10, b=3 -> result=3. Then a=5, b=0 -> error=1, result stays 3, done 2 cycles after the request.
- add_req and mul_req in the same IDLE cycle with a=3, b=4 -> result=7 only; exactly one done pulse; overrun=0.
- mul_req at cycle 0, div_req at cycle 2, add_req at cycle 3 -> mul result delivered, then div with its cycle-2 operands; overrun=1.
- rst=0 at cycle 4 of a mul -> all outputs 0, no done pulse, next add_req runs normally.
